// File: rtl/ldpc_pkg.sv
// Shared types and shift table for the QC-LDPC encoder.
// Soft output is enabled with LDPC_ENC_SOFT_OUT_EN.
package ldpc_pkg;
  localparam int Z = 8;
  localparam int Q = 8;
  localparam int LLR_MAX = 63;
  localparam int ZW = (Z > 1) ? $clog2(Z) : 1;

  typedef logic [Z-1:0] ldpc_sym_t;
  typedef logic signed [Q-1:0] ldpc_llr_t;
  typedef logic [ZW-1:0] rot_amt_t;

  typedef enum logic {
    S_INFO,
    S_PARITY
  } enc_state_e;

  function automatic rot_amt_t shift_amt(
    input int i,
    input int j
  );
    return rot_amt_t'((i * (j + 1)) % Z);
  endfunction
endpackage

// File: rtl/ldpc_circ_rot.sv
// Combinational circulant rotate-left of one symbol.
// Part of ldpc_qc_encoder (LDPC_ENC_SOFT_OUT_EN).
module ldpc_circ_rot
  import ldpc_pkg::*;
(
  input  ldpc_sym_t sym,
  input  rot_amt_t  amt,
  output ldpc_sym_t rot
);
  always_comb begin
    rot = '0;
    for (int b = 0; b < Z; b++)
      rot[b] = sym[rot_amt_t'((b + Z - int'(amt)) % Z)];
  end
endmodule

// File: rtl/ldpc_qc_encoder.sv
// Streaming systematic QC-LDPC encoder, dual-diagonal parity.
// Define LDPC_ENC_SOFT_OUT_EN to add the BPSK LLR output cw_llr_o.
module ldpc_qc_encoder
  import ldpc_pkg::*;
#(
  parameter int K_BLK = 4,
  parameter int M_BLK = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         info_valid_i,
  output logic         info_ready_o,
  input  logic [Z-1:0] info_data_i,
  output logic         cw_valid_o,
  input  logic         cw_ready_i,
  output logic [Z-1:0] cw_data_o,
  output logic         cw_last_o,
  output logic         cw_parity_o,
  output logic         busy_o
`ifdef LDPC_ENC_SOFT_OUT_EN
  ,
  output logic [Z*Q-1:0] cw_llr_o
`endif
);
  localparam int KW = $clog2(K_BLK + 1);
  localparam int MW = (M_BLK > 1) ? $clog2(M_BLK) : 1;

  enc_state_e    state;
  logic [KW-1:0] info_cnt;
  logic [MW-1:0] par_cnt;
  ldpc_sym_t     s     [M_BLK];
  ldpc_sym_t     s_rot [M_BLK];
  ldpc_sym_t     p_run;
  ldpc_sym_t     par_sym;
  logic          free;
  logic          load_info;
  logic          load_par;
  logic          info_last;
  logic          par_last;

  assign free = !cw_valid_o || cw_ready_i;
  assign info_ready_o = (state == S_INFO) && free;
  assign load_info = info_ready_o && info_valid_i;
  assign load_par = (state == S_PARITY) && free;
  assign info_last = info_cnt == KW'(K_BLK - 1);
  assign par_last = par_cnt == MW'(M_BLK - 1);
  assign par_sym = p_run ^ s[par_cnt];
  assign busy_o = (info_cnt != '0) || (state == S_PARITY);

  for (genvar j = 0; j < M_BLK; j++) begin : g_row
    ldpc_circ_rot u_rot (
      .sym (info_data_i),
      .amt (shift_amt(int'(info_cnt), j)),
      .rot (s_rot[j])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_INFO;
      info_cnt    <= '0;
      par_cnt     <= '0;
      p_run       <= '0;
      for (int j = 0; j < M_BLK; j++)
        s[j] <= '0;
      cw_valid_o  <= 1'b0;
      cw_data_o   <= '0;
      cw_last_o   <= 1'b0;
      cw_parity_o <= 1'b0;
    end else if (load_info) begin
      cw_data_o   <= info_data_i;
      cw_valid_o  <= 1'b1;
      cw_parity_o <= 1'b0;
      cw_last_o   <= 1'b0;
      info_cnt    <= info_cnt + 1'b1;
      for (int j = 0; j < M_BLK; j++)
        s[j] <= s[j] ^ s_rot[j];
      if (info_last) begin
        state   <= S_PARITY;
        par_cnt <= '0;
        p_run   <= '0;
      end
    end else if (load_par) begin
      cw_data_o   <= par_sym;
      p_run       <= par_sym;
      cw_parity_o <= 1'b1;
      cw_valid_o  <= 1'b1;
      cw_last_o   <= par_last;
      par_cnt     <= par_cnt + 1'b1;
      if (par_last) begin
        for (int j = 0; j < M_BLK; j++)
          s[j] <= '0;
        info_cnt <= '0;
        par_cnt  <= '0;
        state    <= S_INFO;
      end
    end else if (cw_ready_i) begin
      cw_valid_o <= 1'b0;
    end
  end

`ifdef LDPC_ENC_SOFT_OUT_EN
  ldpc_sym_t       d_nxt;
  logic [Z*Q-1:0]  llr_nxt;

  assign d_nxt = load_info ? info_data_i : par_sym;

  // BPSK map at the decoder's saturation bound
  always_comb begin
    llr_nxt = '0;
    for (int b = 0; b < Z; b++)
      llr_nxt[b*Q +: Q] = d_nxt[b] ? ldpc_llr_t'(-LLR_MAX)
                                   : ldpc_llr_t'(LLR_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cw_llr_o <= '0;
    else if (load_info || load_par)
      cw_llr_o <= llr_nxt;
  end
`endif
endmodule
